// File: rtl/ring_window_pkg.sv
// Shared types and helpers for the circular staging buffer that feeds rotating_xbar.
// Pointer/count widths follow the default slot count of 4.
package ring_window_pkg;

   localparam int RW_NUM_DATA   = 4;
   localparam int RW_DATA_WIDTH = 4;

   typedef logic [$clog2(RW_NUM_DATA)-1:0] ptr_t;
   typedef logic [$clog2(RW_NUM_DATA):0]   cnt_t;

   // Lane j is valid when j < cnt; the result is thermometer-coded from bit 0.
   function automatic logic [RW_NUM_DATA-1:0] thermo_mask(input cnt_t cnt);
      logic [RW_NUM_DATA-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < RW_NUM_DATA; i++) begin
         m[i] = (i < 32'(cnt));
      end
      return m;
   endfunction

endpackage

// File: rtl/ring_window_buffer.sv
// Circular staging buffer: one push per cycle, 0..NUM_DATA pops per cycle from the head.
// Raw slots, head and occupancy are exposed so rotating_xbar can present entries oldest-first.
module ring_window_buffer
   import ring_window_pkg::*;
#(
   parameter int  NUM_DATA   = RW_NUM_DATA,
   parameter int  DATA_WIDTH = RW_DATA_WIDTH,
   localparam int PTR_W      = $clog2(NUM_DATA),
   localparam int CNT_W      = PTR_W + 1
) (
   input  logic                                 clk_i,
   input  logic                                 arst_ni,
   input  logic                                 flush_i,
   input  logic [DATA_WIDTH-1:0]                data_i,
   input  logic                                 data_valid_i,
   output logic                                 data_ready_o,
   input  logic [CNT_W-1:0]                     pop_cnt_i,
   output logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  mem_vector_o,
   output logic [PTR_W-1:0]                     head_o,
   output logic [CNT_W-1:0]                     count_o,
   output logic [NUM_DATA-1:0]                  valid_mask_o
);

   logic [PTR_W-1:0]      head_q, head_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [NUM_DATA];
   logic [DATA_WIDTH-1:0] mem_d [NUM_DATA];

   logic [CNT_W-1:0]      pop_eff;
   logic [PTR_W-1:0]      tail;
   logic                  push;

   // Ready depends on registered occupancy only; reset low forces it off.
   assign data_ready_o = arst_ni & (count_q != CNT_W'(NUM_DATA));

   always_comb begin
      pop_eff = (pop_cnt_i > count_q) ? count_q : pop_cnt_i;
      push    = data_valid_i & data_ready_o & ~flush_i;
      tail    = head_q + count_q[PTR_W-1:0];
      head_d  = head_q;
      count_d = count_q;
      mem_d   = mem_q;
      if (flush_i) begin
         head_d  = '0;
         count_d = '0;
      end else begin
         // Low PTR_W bits of pop_eff give the correct modular advance even when pop_eff == NUM_DATA.
         head_d  = head_q + pop_eff[PTR_W-1:0];
         count_d = count_q - pop_eff + CNT_W'(push);
         if (push) begin
            mem_d[tail] = data_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         head_q  <= '0;
         count_q <= '0;
         for (int k = 0; k < NUM_DATA; k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         head_q  <= head_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;

   for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_mem_out
      assign mem_vector_o[gi] = mem_q[gi];
   end

   if (NUM_DATA == RW_NUM_DATA) begin : g_mask_pkg
      assign valid_mask_o = thermo_mask(count_q);
   end else begin : g_mask_gen
      for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_bit
         assign valid_mask_o[gi] = (count_q > CNT_W'(gi));
      end
   end

endmodule
